// File: rtl/vga_frame_fetch.sv
// Frame buffer between the stream receiver and the VGA pins.
// Loads a raster frame, then serves upscaled pixels with delay-matched syncs.
module vga_frame_fetch #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_W       = 3,
  parameter int ADDR_W      = 15
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             frame_done,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             display_en,
  input  logic             h_sync,
  input  logic             v_sync,
  output logic [PIX_W-1:0] rgb,
  output logic             vga_hs,
  output logic             vga_vs
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              done_q, done_d;
  logic              accept;

  logic [PIX_W-1:0]  mem [2**ADDR_W];
  logic [PIX_W-1:0]  mem_q;

  logic [9:0]        x, y;
  logic              in_img_d;
  logic [ADDR_W-1:0] rd_addr_d;

  logic              in1_q, hs1_q, vs1_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              in2_q, hs2_q, vs2_q;

  // A restart pulse wins over any beat offered in the same cycle.
  assign wr_ready   = (state_q == S_LOAD) && !frame_start;
  assign accept     = wr_valid && wr_ready;
  assign frame_done = done_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = 1'b0;
    if (frame_start) begin
      state_d  = S_LOAD;
      wr_ptr_d = '0;
    end else if (accept) begin
      if (wr_ptr_q == LAST) begin
        state_d  = S_DONE;
        wr_ptr_d = '0;
        done_d   = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= S_WAIT;
      wr_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      done_q   <= done_d;
    end
  end

  assign x = h_count >> SCALE_SHIFT;
  assign y = v_count >> SCALE_SHIFT;

  assign in_img_d = display_en
                 && (32'(x) < IMG_W)
                 && (32'(y) < IMG_H);

  assign rd_addr_d = ADDR_W'(32'(y) * IMG_W + 32'(x));

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      in1_q     <= 1'b0;
      rd_addr_q <= '0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      in2_q     <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
    end else begin
      in1_q     <= in_img_d;
      rd_addr_q <= rd_addr_d;
      hs1_q     <= h_sync;
      vs1_q     <= v_sync;
      in2_q     <= in1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  end

  // Read-before-write on a shared address: the read sees the old word.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
    mem_q <= mem[rd_addr_q];
  end

  assign rgb    = in2_q ? mem_q : '0;
  assign vga_hs = hs2_q;
  assign vga_vs = vs2_q;

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: positional model of the buffer and pipeline
// checked every cycle, plus literal pixel probes.
module tb_vga_frame_fetch;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       frame_done;
  logic [9:0] h_count = '0;
  logic [9:0] v_count = '0;
  logic       display_en = 1'b0;
  logic       h_sync = 1'b1;
  logic       v_sync = 1'b1;
  logic [2:0] rgb;
  logic       vga_hs;
  logic       vga_vs;

  always #5 clk_in = ~clk_in;

  vga_frame_fetch #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .SCALE_SHIFT(2),
    .PIX_W(3),
    .ADDR_W(15)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .frame_start(frame_start),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .frame_done(frame_done),
    .h_count(h_count),
    .v_count(v_count),
    .display_en(display_en),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .rgb(rgb),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory image, load progress, and what each output must show.
  logic [2:0] mmem [NPIX];
  bit         known [NPIX];
  bit         m_load = 0;
  int         m_ptr = 0;
  bit         p_in = 0;
  int         p_addr = 0;
  logic       p_hs = 1, p_vs = 1;
  logic [2:0] e_rgb = 0;
  bit         e_known = 1;
  logic       e_hs = 1, e_vs = 1, e_done = 0;

  initial begin
    int xx, yy;
    for (int i = 0; i < NPIX; i++) known[i] = 0;
    forever begin
      @(posedge clk_in or negedge reset);
      if (!reset) begin
        m_load = 0; m_ptr = 0;
        p_in = 0; p_addr = 0; p_hs = 1; p_vs = 1;
        e_rgb = 0; e_known = 1; e_hs = 1; e_vs = 1; e_done = 0;
      end else begin
        if (p_in) begin
          e_known = known[p_addr];
          e_rgb   = mmem[p_addr];
        end else begin
          e_known = 1;
          e_rgb   = 0;
        end
        e_hs = p_hs;
        e_vs = p_vs;
        xx = int'(h_count) / 4;
        yy = int'(v_count) / 4;
        p_in   = display_en && xx < IMG_W && yy < IMG_H;
        p_addr = yy * IMG_W + xx;
        p_hs   = h_sync;
        p_vs   = v_sync;
        e_done = 0;
        if (frame_start) begin
          m_load = 1;
          m_ptr  = 0;
        end else if (m_load && wr_valid) begin
          mmem[m_ptr]  = wr_data;
          known[m_ptr] = 1;
          if (m_ptr == NPIX - 1) begin
            e_done = 1;
            m_load = 0;
            m_ptr  = 0;
          end else begin
            m_ptr++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (frame_done === 1'b1) done_cnt++;
      chk("wr_ready", wr_ready, m_load && !frame_start);
      chk("frame_done", frame_done, e_done);
      chk("vga_hs", vga_hs, e_hs);
      chk("vga_vs", vga_vs, e_vs);
      if (e_known) chk("rgb", rgb, e_rgb);
    end
  end

  task automatic idle();
    display_en = 0; h_sync = 1; v_sync = 1;
    h_count = '0; v_count = '0;
  endtask

  task automatic probe(input int h, input int v, input bit de,
                       input int exp, input string name);
    @(posedge clk_in); #1;
    h_count = 10'(h); v_count = 10'(v); display_en = de;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    chk(name, rgb, exp);
  endtask

  task automatic pulse_start(input bit with_write);
    @(posedge clk_in); #1;
    frame_start = 1; wr_valid = with_write; wr_data = 3'd3;
    @(posedge clk_in); #1;
    frame_start = 0; wr_valid = 0;
  endtask

  task automatic drive_w(input int idx, input int last, input int mode,
                         input int pct, input bit col);
    wr_valid = (idx < last) && (int'($urandom_range(99)) < pct);
    case (mode)
      0: wr_data = 3'(idx);
      1: wr_data = 3'd7;
      2: wr_data = 3'd5;
      default: wr_data = 3'(idx + 3);
    endcase
    if (col && idx + 1 < NPIX) begin
      h_count = 10'(((idx + 1) % IMG_W) * 4);
      v_count = 10'(((idx + 1) / IMG_W) * 4);
      display_en = 1;
    end
  endtask

  int w_idx, w_rdy;

  task automatic load_px(input int first, input int n, input int mode,
                         input int pct, input bit col);
    int last, cyc;
    bit acc;
    last = first + n; cyc = 0;
    w_idx = first; w_rdy = 0;
    @(posedge clk_in); #1;
    drive_w(w_idx, last, mode, pct, col);
    while (w_idx < last && cyc < 4 * n + 100) begin
      @(negedge clk_in);
      acc = wr_valid && wr_ready;
      if (wr_ready) w_rdy++;
      @(posedge clk_in); #1;
      if (acc) w_idx++;
      cyc++;
      drive_w(w_idx, last, mode, pct, col);
    end
    wr_valid = 0;
    idle();
    chk("load_count", w_idx, last);
  endtask

  task automatic run_line(input int v);
    for (int h = 0; h < 800; h++) begin
      @(posedge clk_in); #1;
      h_count = 10'(h); v_count = 10'(v);
      display_en = (h < 640) && (v < 480);
      h_sync = !(h >= 656 && h < 752);
      v_sync = !(v >= 490 && v < 492);
    end
    @(posedge clk_in); #1;
    idle();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      @(posedge clk_in); #1;
      h_sync = ~h_sync; v_sync = ~v_sync;
      display_en = ~display_en; frame_start = ~frame_start;
      wr_valid = 1; h_count = h_count + 10'd5;
    end
    frame_start = 0; wr_valid = 0;
    idle();
    reset = 1;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    chk("ready_after_reset", wr_ready, 0);

    pulse_start(0);
    load_px(0, NPIX, 0, 100, 0);
    chk("ready_beats", w_rdy, NPIX);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("done_once", done_cnt, 1);
    chk("ready_after_done", wr_ready, 0);

    probe(4, 0, 1, 1, "px_h4_v0");
    probe(7, 4, 1, 1, "px_h7_v4");
    probe(639, 479, 1, 7, "px_h639_v479");
    probe(0, 0, 1, 0, "px_h0_v0");
    idle();

    @(posedge clk_in); #1;
    h_sync = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("hs_lag1", vga_hs, 1);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("hs_lag2", vga_hs, 0);
    @(posedge clk_in); #1;
    h_sync = 1;

    run_line(0);
    run_line(1);
    run_line(4);
    run_line(479);
    run_line(480);
    run_line(490);

    pulse_start(0);
    load_px(0, 100, 1, 100, 0);
    probe(0, 0, 1, 7, "img_px0_is7");
    probe(640, 0, 0, 0, "blank_h640");
    probe(799, 10, 0, 0, "blank_h799");
    probe(100, 480, 0, 0, "blank_v480");
    probe(640, 0, 1, 0, "oob_x160");
    probe(0, 480, 1, 0, "oob_y120");
    idle();

    pulse_start(1);
    load_px(0, 5, 2, 100, 0);
    probe(0, 0, 1, 5, "restart_px0");
    probe(16, 0, 1, 5, "restart_px4");
    probe(20, 0, 1, 7, "keep_px5");
    probe(396, 0, 1, 7, "keep_px99");
    probe(400, 0, 1, 4, "keep_px100");
    idle();
    chk("no_done_restart", done_cnt, 1);

    load_px(5, NPIX - 5, 3, 75, 1);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("done_twice", done_cnt, 2);
    chk("ready_after_done2", wr_ready, 0);
    probe(20, 0, 1, 0, "new_px5");
    probe(4, 0, 1, 5, "new_px1");
    probe(7, 4, 1, 4, "new_px161");
    probe(639, 479, 1, 2, "new_px19199");
    idle();
    repeat (2) @(posedge clk_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_fetch.md
Name: vga_frame_fetch

Overview:
- Pixel-fetch stage directly downstream of vga_sync in the image-receiver design.
- Holds a dual-port frame buffer. The write side loads a frame through a valid/ready stream from the upstream receiver.
- The read side turns vga_sync's h_count/v_count/display_en/h_sync/v_sync into registered RGB plus sync outputs, with the syncs delay-matched to the pixel data.
- The stored image is upscaled by 2^SCALE_SHIFT in both axes. Pixels outside the image area are driven black.

Parameters:
IMG_W, 160, stored image width in pixels
IMG_H, 120, stored image height in pixels
SCALE_SHIFT, 2, upscale factor exponent (2 -> 4x, so 160x120 fills 640x480)
PIX_W, 3, bits per pixel ({r,g,b} one bit each by default)
ADDR_W, 15, buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk_in  input  1  pixel clock (the clk_sys output of vga_sync)
reset  input  1  asynchronous, active-low reset (asserted when 0)
frame_start  input  1  single-cycle pulse; restarts loading at pixel 0
wr_data  input  PIX_W  pixel to store, raster order
wr_valid  input  1  wr_data is valid
wr_ready  output  1  block accepts wr_data this cycle
frame_done  output  1  single-cycle pulse after the last pixel of a frame is written
h_count  input  10  horizontal position from vga_sync
v_count  input  10  vertical position from vga_sync
display_en  input  1  active-area flag from vga_sync
h_sync  input  1  from vga_sync, active-low
v_sync  input  1  from vga_sync, active-low
rgb  output  PIX_W  pixel to the DAC pins
vga_hs  output  1  h_sync delayed to align with rgb
vga_vs  output  1  v_sync delayed to align with rgb

Behaviour:
- Reset (reset=0, asynchronous): rgb=0, vga_hs=1, vga_vs=1, wr_ready=0, frame_done=0, write FSM=WAIT, wr_ptr=0, all pipeline registers cleared, delayed sync registers set to 1. Buffer contents are not cleared.
- Write FSM has three states: WAIT, LOAD, DONE.
  - WAIT: wr_ready=0. frame_start -> LOAD with wr_ptr=0.
  - LOAD: wr_ready=1. A pixel is accepted when wr_valid&&wr_ready: mem[wr_ptr]<=wr_data, then wr_ptr++.
  - Accepting the pixel at wr_ptr==IMG_W*IMG_H-1: frame_done=1 on the next cycle, state -> DONE, wr_ptr -> 0.
  - DONE: wr_ready=0. frame_start -> LOAD.
- frame_start in any state, including mid-LOAD, forces LOAD with wr_ptr=0. A write arriving in the same cycle as frame_start is dropped (wr_ready is 0 that cycle).
- wr_ready is a registered state decode; it does not depend combinationally on wr_valid.
- Read pipeline, fixed latency 2 cycles from the h_count/v_count/display_en/sync inputs to rgb/vga_hs/vga_vs:
  - Stage 1 (registered):
    - x = h_count>>SCALE_SHIFT, y = v_count>>SCALE_SHIFT.
    - in_img = display_en && x<IMG_W && y<IMG_H.
    - rd_addr = y*IMG_W + x, computed at ADDR_W width (constant multiply; no overflow while in_img).
    - h_sync/v_sync/in_img captured.
  - Stage 2 (registered): synchronous memory read of rd_addr. rgb = in_img_d ? mem_q : 0. vga_hs/vga_vs = stage-1 syncs.
- When the read and write addresses collide in the same cycle, the read returns the old data (read-before-write).
- No double buffering: writes during display are visible on the next fetch (tearing is acceptable).
- Out-of-image region (x>=IMG_W or y>=IMG_H) and blanking always give rgb=0 regardless of memory contents.
- h_count wrap 799->0 and v_count wrap 524->0 need no special handling; the pipeline is purely positional.

Test Plan:
- Reset: hold reset=0 for 3 cycles with toggling inputs -> rgb=0, vga_hs=1, vga_vs=1, wr_ready=0 throughout; after release, wr_ready stays 0 until frame_start.
- Full load: frame_start, then 19200 pixels with wr_data = addr mod 8 and wr_valid always 1 -> wr_ready high for exactly 19200 accepts, frame_done pulses once on the following cycle, then wr_ready=0.
- Readback and upscale: after the full load, sweep one frame via a vga_sync model -> at (h=4,v=0) rgb=mem[1]=1; at (h=7,v=4) rgb=mem[161]=1; at (h=639,v=479) rgb=mem[19199]=7. Each output sample appears 2 cycles after the counters; vga_hs falls 2 cycles after h_sync falls.
- Blanking: at h_count=640..799 or v_count>=480 -> rgb=0 while mem[0]=7.
- Restart mid-load: frame_start after 100 accepts, then 5 pixels of value 5 -> mem[0..4]=5 and mem[5..99] keep their old values; no frame_done until 19200 further accepts.
- Backpressure and collision: toggle wr_valid randomly -> only valid&&ready beats are written. Writing address N while reading N returns the old value that cycle and the new value on the next frame.
